// File: rtl/io_control_unit.sv
// io_control_unit: Moore fetch/execute sequencer (clk, clr async active-low, IR, stop -> fetch/execute strobes, run, instr_count)
module io_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        stop,
  output logic        PCout,
  output logic        MARin,
  output logic        MDRin,
  output logic        Read,
  output logic        MDRout,
  output logic        IRin,
  output logic        PCin,
  output logic        IncPC,
  output logic        Gra,
  output logic        R_in,
  output logic        R_out,
  output logic        Yin,
  output logic        enableOutputPort,
  output logic        InPortout,
  output logic        HIout,
  output logic        LOout,
  output logic        run,
  output logic [15:0] instr_count
);
  typedef enum logic [2:0] {RESET, T0, T1, T2, T3, HALT} state_t;
  state_t state, nxt;
  logic [15:0] cnt;
  logic [4:0] op;
  logic is_out, is_in, is_hi, is_lo;
  logic unused_ir;
  assign op = IR[31:27];
  assign unused_ir = ^IR[26:0];
  assign is_out = op == 5'b10110;
  assign is_in = op == 5'b10101;
  assign is_hi = op == 5'b10111;
  assign is_lo = op == 5'b11000;
  assign instr_count = cnt;
  always_ff @(posedge clk or negedge clr)
    if (!clr) begin
      state <= RESET;
      cnt <= 16'h0000;
    end else begin
      state <= nxt;
      if (state == T3) cnt <= cnt + 16'd1;
    end
  always_comb begin
    nxt = state;
    {PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC} = '0;
    {Gra, R_in, R_out, Yin, enableOutputPort, InPortout, HIout, LOout} = '0;
    run = 1'b0;
    case (state)
      RESET: nxt = T0;
      T0: begin
        nxt = T1;
        run = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
      end
      T1: begin
        nxt = T2;
        run = 1'b1;
        MDRin = 1'b1;
        Read = 1'b1;
      end
      T2: begin
        nxt = T3;
        run = 1'b1;
        MDRout = 1'b1;
        IRin = 1'b1;
        PCin = 1'b1;
        IncPC = 1'b1;
      end
      T3: begin
        nxt = (op == 5'b11010 || stop) ? HALT : T0;
        run = 1'b1;
        Gra = is_out | is_in | is_hi | is_lo;
        R_out = is_out;
        Yin = is_out;
        enableOutputPort = is_out;
        R_in = is_in | is_hi | is_lo;
        InPortout = is_in;
        HIout = is_hi;
        LOout = is_lo;
      end
      default: nxt = HALT;
    endcase
  end
endmodule

// File: tb/tb_io_control_unit.sv
// tb_io_control_unit: directed self-checking bench for io_control_unit
module tb_io_control_unit;
  logic clk = 1'b0, clr = 1'b0, stop = 1'b0;
  logic [31:0] IR = 32'h0;
  logic PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC;
  logic Gra, R_in, R_out, Yin, enableOutputPort, InPortout, HIout, LOout, run;
  logic [15:0] instr_count;
  logic [15:0] ctrl;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  assign ctrl = {PCout, MARin, MDRin, Read, MDRout, IRin, PCin, IncPC,
                 Gra, R_in, R_out, Yin, enableOutputPort, InPortout, HIout, LOout};
  io_control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .stop(stop),
    .PCout(PCout), .MARin(MARin), .MDRin(MDRin), .Read(Read),
    .MDRout(MDRout), .IRin(IRin), .PCin(PCin), .IncPC(IncPC),
    .Gra(Gra), .R_in(R_in), .R_out(R_out), .Yin(Yin),
    .enableOutputPort(enableOutputPort), .InPortout(InPortout),
    .HIout(HIout), .LOout(LOout), .run(run), .instr_count(instr_count)
  );
  localparam logic [15:0] C_T0 = 16'hC000, C_T1 = 16'h3000, C_T2 = 16'h0F00;
  localparam logic [15:0] C_OUT = 16'h00B8, C_IN = 16'h00C4, C_HI = 16'h00C2, C_LO = 16'h00C1;
  task automatic restart();
    clr = 1'b0;
    stop = 1'b0;
    @(negedge clk);
    clr = 1'b1;
  endtask
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask
  task automatic test_reset();
    clr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({ctrl, run, instr_count} !== 33'h0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: ctrl=%h run=%b cnt=%h, want all 0", i, ctrl, run, instr_count);
      end
    end
  endtask
  task automatic test_out();
    logic [15:0] exp [4];
    exp = '{C_T0, C_T1, C_T2, C_OUT};
    restart();
    IR = 32'hB0800000;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (ctrl !== exp[i] || run !== 1'b1) begin
        bad++;
        $display("FAIL out_T%0d: ctrl=%h run=%b, want ctrl=%h run=1", i, ctrl, run, exp[i]);
      end
    end
    step(1);
    total++;
    if (ctrl !== C_T0 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL out_next_T0: ctrl=%h cnt=%0d, want ctrl=%h cnt=1", ctrl, instr_count, C_T0);
    end
  endtask
  task automatic test_in();
    restart();
    IR = 32'hA8800000;
    step(4);
    total++;
    if (ctrl !== C_IN || R_out !== 1'b0) begin
      bad++;
      $display("FAIL in_T3: ctrl=%h R_out=%b, want ctrl=%h R_out=0", ctrl, R_out, C_IN);
    end
  endtask
  task automatic test_mf();
    restart();
    IR = 32'hB8000000;
    step(4);
    total++;
    if (ctrl !== C_HI) begin
      bad++;
      $display("FAIL mfhi_T3: ctrl=%h, want %h", ctrl, C_HI);
    end
    step(1);
    IR = 32'hC0000000;
    step(3);
    total++;
    if (ctrl !== C_LO) begin
      bad++;
      $display("FAIL mflo_T3: ctrl=%h, want %h", ctrl, C_LO);
    end
    step(1);
    total++;
    if (instr_count !== 16'd2) begin
      bad++;
      $display("FAIL mf_count: cnt=%0d, want 2", instr_count);
    end
  endtask
  task automatic test_halt();
    restart();
    IR = 32'hD0000000;
    step(4);
    total++;
    if (ctrl !== 16'h0 || run !== 1'b1) begin
      bad++;
      $display("FAIL halt_T3: ctrl=%h run=%b, want ctrl=0 run=1", ctrl, run);
    end
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (ctrl !== 16'h0 || run !== 1'b0 || instr_count !== 16'd1) begin
        bad++;
        $display("FAIL halt_hold %0d: ctrl=%h run=%b cnt=%0d, want 0/0/1", i, ctrl, run, instr_count);
      end
    end
  endtask
  task automatic test_midreset();
    restart();
    IR = 32'hB0800000;
    step(7);
    total++;
    if (ctrl !== C_T2 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL mid_pre_T2: ctrl=%h cnt=%0d, want %h cnt=1", ctrl, instr_count, C_T2);
    end
    #1 clr = 1'b0;
    #1;
    total++;
    if (ctrl !== 16'h0 || run !== 1'b0 || instr_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_async_clear: ctrl=%h run=%b cnt=%0d, want all 0", ctrl, run, instr_count);
    end
    #2 clr = 1'b1;
    step(1);
    total++;
    if (ctrl !== C_T0 || run !== 1'b1 || instr_count !== 16'd0) begin
      bad++;
      $display("FAIL mid_restart_T0: ctrl=%h run=%b cnt=%0d, want %h/1/0", ctrl, run, instr_count, C_T0);
    end
  endtask
  task automatic test_stop();
    restart();
    IR = 32'hC8000000;
    step(2);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    step(1);
    total++;
    if (ctrl !== 16'h0 || run !== 1'b1) begin
      bad++;
      $display("FAIL nop_T3: ctrl=%h run=%b, want 0/1", ctrl, run);
    end
    step(1);
    total++;
    if (ctrl !== C_T0 || run !== 1'b1 || instr_count !== 16'd1) begin
      bad++;
      $display("FAIL stop_ignored: ctrl=%h run=%b cnt=%0d, want %h/1/1", ctrl, run, instr_count, C_T0);
    end
    step(3);
    stop = 1'b1;
    step(1);
    stop = 1'b0;
    total++;
    if (ctrl !== 16'h0 || run !== 1'b0 || instr_count !== 16'd2) begin
      bad++;
      $display("FAIL stop_halts: ctrl=%h run=%b cnt=%0d, want 0/0/2", ctrl, run, instr_count);
    end
    step(2);
    total++;
    if (run !== 1'b0 || instr_count !== 16'd2) begin
      bad++;
      $display("FAIL stop_halt_hold: run=%b cnt=%0d, want 0/2", run, instr_count);
    end
  endtask
  task automatic test_wrap();
    restart();
    IR = 32'hC8000000;
    step(1);
    force dut.cnt = 16'hFFFF;
    #1 release dut.cnt;
    total++;
    if (instr_count !== 16'hFFFF) begin
      bad++;
      $display("FAIL wrap_preload: cnt=%h, want ffff", instr_count);
    end
    step(4);
    total++;
    if (instr_count !== 16'h0000 || ctrl !== C_T0) begin
      bad++;
      $display("FAIL wrap: cnt=%h ctrl=%h, want 0000/%h", instr_count, ctrl, C_T0);
    end
  endtask
  initial begin
    test_reset();
    test_out();
    test_in();
    test_mf();
    test_halt();
    test_midreset();
    test_stop();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
